// File: rtl/ctu_clsp_pkg.sv
// Shared types and constants for the DDR cluster clock/reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ctu_clsp_pkg;

    localparam int CLSP_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_CKWAIT = 3'd1,
        ST_RUN    = 3'd2,
        ST_DBG    = 3'd3,
        ST_STOP   = 3'd4
    } clsp_state_e;

endpackage

// File: rtl/ctu_clsp_dncnt.sv
// Loadable down-counter that is shared by every timed sequencer state.
// Latency: load and decrement both take effect on the next edge.
// Backpressure: none; decrement holds at zero and never wraps.
//
// Ports: clk/rst (sync, active-high), load + load_val, dec, cnt, zero.
module ctu_clsp_dncnt
    import ctu_clsp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CLSP_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic [CLSP_CNT_W-1:0] cnt,
    output logic                  zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ctu_ddr_clsp.sv
// DDR cluster clock/reset sequencer: orders cluster_cken against grst_l/gdbginit_l.
// Latency: request sampled at edge t acts at t+1; sequences last CKEN_DLY/DBG_HOLD/STOP_DLY cycles.
// Backpressure: none; requests outside OFF/RUN are dropped, never queued.
//
// Ports: gclk, rst (sync, active-high); start_req/dbg_req/stop_req pulses in;
// cluster_cken, grst_l, gdbginit_l to the headers; busy, done (1-cycle), run status.
module ctu_ddr_clsp
    import ctu_clsp_pkg::*;
#(
    parameter int CKEN_DLY = 8,
    parameter int DBG_HOLD = 4,
    parameter int STOP_DLY = 4
) (
    input  logic gclk,
    input  logic rst,
    input  logic start_req,
    input  logic dbg_req,
    input  logic stop_req,
    output logic cluster_cken,
    output logic grst_l,
    output logic gdbginit_l,
    output logic busy,
    output logic done,
    output logic run
);

    // The counter is loaded with N-1 so the timed state lasts exactly N cycles
    // (the exit is taken on the cycle the counter reads zero).
    localparam logic [CLSP_CNT_W-1:0] CKEN_LD = CLSP_CNT_W'(CKEN_DLY - 1);
    localparam logic [CLSP_CNT_W-1:0] DBG_LD  = CLSP_CNT_W'(DBG_HOLD - 1);
    localparam logic [CLSP_CNT_W-1:0] STOP_LD = CLSP_CNT_W'(STOP_DLY - 1);

    clsp_state_e           state_q;
    clsp_state_e           state_d;
    logic                  cnt_load;
    logic [CLSP_CNT_W-1:0] cnt_load_val;
    logic                  cnt_dec;
    logic [CLSP_CNT_W-1:0] cnt;
    logic                  cnt_zero;

    logic cken_d;
    logic grst_l_d;
    logic gdbginit_l_d;
    logic busy_d;
    logic done_d;
    logic run_d;

    ctu_clsp_dncnt u_dncnt (
        .clk      (gclk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Next-state and next-output logic. Outputs are decoded from the next
    // state so every output register changes on the same edge as the state.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                if (start_req) begin
                    state_d      = ST_CKWAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = CKEN_LD;
                end
            end
            ST_CKWAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RUN: begin
                // Shutdown wins over debug-init when both arrive together.
                if (stop_req) begin
                    state_d      = ST_STOP;
                    cnt_load     = 1'b1;
                    cnt_load_val = STOP_LD;
                end else if (dbg_req) begin
                    state_d      = ST_DBG;
                    cnt_load     = 1'b1;
                    cnt_load_val = DBG_LD;
                end
            end
            ST_DBG: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_zero) begin
                    state_d = ST_OFF;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Reset/debug-init are only released in states where the clock is
        // already enabled, and the clock only drops from OFF, which keeps
        // grst_l low whenever cken is low.
        cken_d       = (state_d != ST_OFF);
        grst_l_d     = (state_d == ST_RUN) || (state_d == ST_DBG);
        gdbginit_l_d = (state_d == ST_RUN);
        busy_d       = (state_d == ST_CKWAIT) || (state_d == ST_DBG) ||
                       (state_d == ST_STOP);
        run_d        = (state_d == ST_RUN);
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            cluster_cken <= 1'b0;
            grst_l       <= 1'b0;
            gdbginit_l   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            run          <= 1'b0;
        end else begin
            state_q      <= state_d;
            cluster_cken <= cken_d;
            grst_l       <= grst_l_d;
            gdbginit_l   <= gdbginit_l_d;
            busy         <= busy_d;
            done         <= done_d;
            run          <= run_d;
        end
    end

endmodule

// File: tb/tb_ctu_ddr_clsp.sv
// Directed bench for the DDR cluster clock/reset sequencer.
// Latency: inputs driven #1 after posedge, outputs sampled the same way.
// Backpressure: n/a.
module tb_ctu_ddr_clsp;

    logic gclk;
    logic rst;
    logic start_req;
    logic dbg_req;
    logic stop_req;
    logic cluster_cken;
    logic grst_l;
    logic gdbginit_l;
    logic busy;
    logic done;
    logic run;

    int chk_cnt;
    int err_cnt;

    ctu_ddr_clsp #(
        .CKEN_DLY (8),
        .DBG_HOLD (4),
        .STOP_DLY (4)
    ) dut (
        .gclk         (gclk),
        .rst          (rst),
        .start_req    (start_req),
        .dbg_req      (dbg_req),
        .stop_req     (stop_req),
        .cluster_cken (cluster_cken),
        .grst_l       (grst_l),
        .gdbginit_l   (gdbginit_l),
        .busy         (busy),
        .done         (done),
        .run          (run)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge, then settle; also checks the cken/reset ordering invariant.
    task automatic step();
        @(posedge gclk);
        #1;
        chk("inv_cken_low", {7'd0, (!cluster_cken && (grst_l || gdbginit_l))}, 8'd0);
    endtask

    // Outputs packed as {cken, grst_l, gdbginit_l, busy, done, run}.
    function automatic logic [7:0] outs();
        return {2'b00, cluster_cken, grst_l, gdbginit_l, busy, done, run};
    endfunction

    initial begin
        chk_cnt   = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        start_req = 1'b0;
        dbg_req   = 1'b0;
        stop_req  = 1'b0;

        // Reset held for 3 edges.
        repeat (3) step();
        chk("reset_outs", outs(), 8'b00_000000);
        rst = 1'b0;
        step();
        chk("idle_outs", outs(), 8'b00_000000);

        // stop_req / dbg_req in OFF are ignored.
        stop_req = 1'b1;
        dbg_req  = 1'b1;
        step();
        stop_req = 1'b0;
        dbg_req  = 1'b0;
        chk("off_ignore_req", outs(), 8'b00_000000);
        step();
        chk("off_ignore_req2", outs(), 8'b00_000000);

        // Bring-up: cken/busy one cycle after the request.
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        chk("bringup_t1", outs(), 8'b00_100100);
        // dbg_req during CKWAIT is dropped and must not disturb timing.
        dbg_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            dbg_req = 1'b0;
            chk("ckwait_hold", outs(), 8'b00_100100);
        end
        step();
        chk("bringup_done", outs(), 8'b00_111011);
        step();
        chk("run_done_low", outs(), 8'b00_111001);

        // start_req in RUN is ignored.
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        chk("run_ignore_start", outs(), 8'b00_111001);

        // Debug-init: gdbginit_l low for 4 cycles, grst_l stays high.
        dbg_req = 1'b1;
        step();
        dbg_req = 1'b0;
        chk("dbg_t1", outs(), 8'b00_110100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dbg_hold", outs(), 8'b00_110100);
        end
        step();
        chk("dbg_done", outs(), 8'b00_111011);
        step();
        chk("dbg_after", outs(), 8'b00_111001);

        // stop_req + dbg_req together: STOP wins.
        stop_req = 1'b1;
        dbg_req  = 1'b1;
        step();
        stop_req = 1'b0;
        dbg_req  = 1'b0;
        chk("stop_t1", outs(), 8'b00_100100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stop_hold", outs(), 8'b00_100100);
        end
        step();
        chk("stop_done", outs(), 8'b00_000010);
        step();
        chk("stop_after", outs(), 8'b00_000000);

        // Reset in the middle of CKWAIT: counter at 3.
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        repeat (4) step();
        chk("ckwait_mid", outs(), 8'b00_100100);
        rst = 1'b1;
        step();
        chk("abort_outs", outs(), 8'b00_000000);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_done", outs(), 8'b00_000000);
        end

        // Full delay again after the abort.
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        chk("rebringup_t1", outs(), 8'b00_100100);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rebringup_hold", outs(), 8'b00_100100);
        end
        step();
        chk("rebringup_done", outs(), 8'b00_111011);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
